pipeline_exmem: RTL and testbench
=================================

PIPELINE_EXMEM -- requirements
Module: pipeline_exmem

Interface
REQ-001 The module SHALL have these ports: CLK in 1, rising-edge clock for all state.
REQ-002 nRST in 1; synchronous, active-high reset (1 = reset, sampled on CLK rising edge).
REQ-003 en in 1: EX stage offers new contents. flush in 1: replace offered contents with a bubble.
REQ-004 EX inputs, all in: ex_valid 1, ex_aluout 32, ex_storedata 32, ex_npc 32, ex_wsel 5, ex_regen 1, ex_regsrc 2, ex_dmemREN 1, ex_dmemWEN 1, ex_halt 1.
REQ-005 Cache side: dmemREN out 1, dmemWEN out 1, dmemaddr out 32, dmemstore out 32, dhit in 1, dmemload in 32.
REQ-006 WB side, all out: mem_valid 1, mem_wsel 5, mem_regen 1, mem_regsrc 2, mem_aluout 32, mem_npc 32, mem_loaddata 32, mem_halt 1.
REQ-007 mem_stall out 1: a data access is pending; upstream stages hold.

Function
REQ-008 The module SHALL implement a state machine with states IDLE, REQ and HALTED.
REQ-009 A capture SHALL occur on a rising edge when en=1, mem_stall=0 and state is not HALTED.
REQ-010 A capture with flush=0 SHALL register all ex_* fields into the corresponding latched fields.
REQ-011 A capture with flush=1 SHALL register a bubble: valid, regen, REN, WEN and halt = 0; other fields don't-care.
REQ-012 If no capture occurs, all latched fields SHALL hold.
REQ-013 IDLE -> REQ on a capture of a valid, unflushed instruction with ex_dmemREN or ex_dmemWEN set.
REQ-014 IDLE -> HALTED on a capture of a valid, unflushed instruction with ex_halt=1; halt takes priority over a memory op.
REQ-015 REQ -> IDLE on a rising edge with dhit=1. REQ holds while dhit=0. HALTED is exited only by reset.
REQ-016 If REN and WEN are both latched, WEN SHALL take priority; REN SHALL be suppressed and loaddata SHALL be unchanged.
REQ-017 In REQ: dmemREN = latched REN & !latched WEN; dmemWEN = latched WEN; dmemaddr = latched aluout; dmemstore = latched storedata. Outside REQ both enables SHALL be 0.
REQ-018 mem_stall SHALL equal (state==REQ) & !dhit, combinationally, so a same-cycle dhit gives a one-cycle access with no stall.
REQ-019 On a REQ edge with dhit=1 and a read, dmemload SHALL be registered into loaddata.
REQ-020 mem_loaddata SHALL be dmemload while in REQ with dhit=1, and the registered loaddata otherwise.
REQ-021 mem_regen SHALL be latched regen & latched valid & !mem_stall, so WB never commits a stalled load.
REQ-022 mem_valid SHALL be latched valid & !mem_stall.
REQ-023 mem_halt SHALL be 1 exactly while in HALTED.
REQ-024 flush asserted while in REQ SHALL be ignored, because no capture occurs; the pending access completes.
REQ-025 en=1 together with mem_stall=1 SHALL NOT capture; the EX contents are re-offered by the held upstream.

Reset
REQ-026 On a rising edge with nRST=1, the module SHALL set state to IDLE and clear all latched fields and loaddata to 0. This SHALL override any capture, dhit or halt in the same cycle.
REQ-027 Under reset, every output SHALL be 0, including dmemREN, dmemWEN and mem_stall.
REQ-028 Reset during REQ SHALL abandon the access; the enables deassert in the following cycle.

Structure
REQ-029 The state enum exmem_state_t {IDLE, REQ, HALTED} and the regsrc encoding SHALL live in cpu_types_pkg, alongside regbits_t and word_t.
REQ-030 Field registers and the FSM SHALL live in one module; no sub-module is required.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Reset: nRST=1 for 2 cycles with en=1 and ex_valid=1 -> all outputs 0, state IDLE.
- Load, dhit=0 for 3 cycles: capture lw to aluout=0x0000_0040 -> dmemREN=1, dmemaddr=0x40, mem_stall=1 for 3 cycles. Then dhit=1 with dmemload=0xDEADBEEF -> mem_loaddata=0xDEADBEEF, mem_regen=1, mem_stall=0. Next cycle dmemREN=0.
- Store with same-cycle dhit: ex_dmemWEN=1, storedata=0x1234 -> dmemWEN=1 and dmemstore=0x1234 for exactly 1 cycle; mem_stall never rises.
- Flush during stall: flush=1 and en=1 while in REQ with dhit=0 -> access continues. After dhit, the next capture with flush=1 gives mem_valid=0, mem_regen=0.
- Halt: capture with ex_halt=1 and ex_dmemREN=1 -> mem_halt=1 and dmemREN stays 0. Later en pulses change no output until reset.
- Reset mid-access: assert nRST in REQ -> next cycle dmemREN=0, mem_stall=0, mem_loaddata=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word/register widths, write-back source encoding and the
// EX/MEM latch layout and state machine states.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [1:0] {
        REGSRC_ALU  = 2'd0,
        REGSRC_LOAD = 2'd1,
        REGSRC_NPC  = 2'd2,
        REGSRC_IMM  = 2'd3
    } regsrc_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HALTED = 2'd2
    } exmem_state_t;

    typedef struct packed {
        logic     valid;
        word_t    aluout;
        word_t    storedata;
        word_t    npc;
        regbits_t wsel;
        logic     regen;
        regsrc_t  regsrc;
        logic     ren;
        logic     wen;
        logic     halt;
    } exmem_fields_t;

    // A bubble carries no side effects; the remaining fields are don't-care.
    localparam exmem_fields_t EXMEM_BUBBLE = '0;

    function automatic logic is_mem_op(input logic ren, input logic wen);
        return ren | wen;
    endfunction

endpackage

// File: rtl/pipeline_exmem.sv
// EX/MEM pipeline latch with data-cache handshake: holds the instruction
// leaving EX, drives one cache access per memory op and stalls until dhit.
module pipeline_exmem
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        en,
    input  logic        flush,

    input  logic        ex_valid,
    input  logic [31:0] ex_aluout,
    input  logic [31:0] ex_storedata,
    input  logic [31:0] ex_npc,
    input  logic [4:0]  ex_wsel,
    input  logic        ex_regen,
    input  logic [1:0]  ex_regsrc,
    input  logic        ex_dmemREN,
    input  logic        ex_dmemWEN,
    input  logic        ex_halt,

    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    input  logic        dhit,
    input  logic [31:0] dmemload,

    output logic        mem_valid,
    output logic [4:0]  mem_wsel,
    output logic        mem_regen,
    output logic [1:0]  mem_regsrc,
    output logic [31:0] mem_aluout,
    output logic [31:0] mem_npc,
    output logic [31:0] mem_loaddata,
    output logic        mem_halt,
    output logic        mem_stall
);

    exmem_state_t  state_q, state_d;
    exmem_fields_t fields_q, fields_d;
    word_t         loaddata_q, loaddata_d;

    logic in_req;
    logic stall;
    logic capture;
    logic dispatch;
    logic rd_access;
    exmem_fields_t offered;

    assign in_req    = (state_q == REQ);
    assign stall     = in_req & ~dhit;
    assign capture   = en & ~stall & (state_q != HALTED);
    assign dispatch  = capture & ~flush & ex_valid;
    assign rd_access = fields_q.ren & ~fields_q.wen;

    always_comb begin
        offered           = EXMEM_BUBBLE;
        offered.valid     = ex_valid;
        offered.aluout    = ex_aluout;
        offered.storedata = ex_storedata;
        offered.npc       = ex_npc;
        offered.wsel      = ex_wsel;
        offered.regen     = ex_regen;
        offered.regsrc    = regsrc_t'(ex_regsrc);
        offered.ren       = ex_dmemREN;
        offered.wen       = ex_dmemWEN;
        offered.halt      = ex_halt;
    end

    always_comb begin
        fields_d = fields_q;
        if (capture) begin
            fields_d = flush ? EXMEM_BUBBLE : offered;
        end
    end

    always_comb begin
        loaddata_d = loaddata_q;
        if (in_req && dhit && rd_access) begin
            loaddata_d = dmemload;
        end
    end

    // A capture on the edge that completes an access dispatches the next
    // instruction directly, so back-to-back memory ops are not dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = IDLE;
            REQ:     if (dhit) state_d = IDLE;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
        if (dispatch) begin
            if (ex_halt) begin
                state_d = HALTED;
            end else if (is_mem_op(ex_dmemREN, ex_dmemWEN)) begin
                state_d = REQ;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q    <= IDLE;
            fields_q   <= EXMEM_BUBBLE;
            loaddata_q <= '0;
        end else begin
            state_q    <= state_d;
            fields_q   <= fields_d;
            loaddata_q <= loaddata_d;
        end
    end

    always_comb begin
        dmemREN      = in_req & rd_access;
        dmemWEN      = in_req & fields_q.wen;
        dmemaddr     = fields_q.aluout;
        dmemstore    = fields_q.storedata;

        mem_stall    = stall;
        mem_valid    = fields_q.valid & ~stall;
        mem_regen    = fields_q.regen & fields_q.valid & ~stall;
        mem_wsel     = fields_q.wsel;
        mem_regsrc   = fields_q.regsrc;
        mem_aluout   = fields_q.aluout;
        mem_npc      = fields_q.npc;
        mem_loaddata = (in_req && dhit) ? dmemload : loaddata_q;
        // HALTED is only entered by latching a halt, which then holds.
        mem_halt     = (state_q == HALTED) & fields_q.halt;
    end

endmodule

// File: tb/tb_pipeline_exmem.sv
// Directed and randomized bench for pipeline_exmem against a behavioural
// model of the latch, the pending access and the halt condition.
module tb_pipeline_exmem;

    logic        CLK = 1'b0;
    logic        nRST, en, flush;
    logic        ex_valid, ex_regen, ex_dmemREN, ex_dmemWEN, ex_halt;
    logic [31:0] ex_aluout, ex_storedata, ex_npc;
    logic [4:0]  ex_wsel;
    logic [1:0]  ex_regsrc;
    logic        dmemREN, dmemWEN, dhit;
    logic [31:0] dmemaddr, dmemstore, dmemload;
    logic        mem_valid, mem_regen, mem_halt, mem_stall;
    logic [4:0]  mem_wsel;
    logic [1:0]  mem_regsrc;
    logic [31:0] mem_aluout, mem_npc, mem_loaddata;

    int checks = 0;
    int errors = 0;

    // model: pending access, halted flag, latched instruction, last load
    bit          m_pend, m_halted;
    bit          m_valid, m_regen, m_ren, m_wen;
    logic [31:0] m_alu, m_store, m_npc, m_load;
    logic [4:0]  m_wsel;
    logic [1:0]  m_regsrc;

    always #5 CLK = ~CLK;

    pipeline_exmem dut (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
        .ex_valid(ex_valid), .ex_aluout(ex_aluout), .ex_storedata(ex_storedata),
        .ex_npc(ex_npc), .ex_wsel(ex_wsel), .ex_regen(ex_regen),
        .ex_regsrc(ex_regsrc), .ex_dmemREN(ex_dmemREN), .ex_dmemWEN(ex_dmemWEN),
        .ex_halt(ex_halt),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
        .mem_valid(mem_valid), .mem_wsel(mem_wsel), .mem_regen(mem_regen),
        .mem_regsrc(mem_regsrc), .mem_aluout(mem_aluout), .mem_npc(mem_npc),
        .mem_loaddata(mem_loaddata), .mem_halt(mem_halt), .mem_stall(mem_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit s;
        s = m_pend && !dhit;
        chk({tag, "/stall"},  {31'd0, mem_stall}, {31'd0, s});
        chk({tag, "/ren"},    {31'd0, dmemREN},   {31'd0, m_pend && m_ren && !m_wen});
        chk({tag, "/wen"},    {31'd0, dmemWEN},   {31'd0, m_pend && m_wen});
        chk({tag, "/valid"},  {31'd0, mem_valid}, {31'd0, m_valid && !s});
        chk({tag, "/regen"},  {31'd0, mem_regen}, {31'd0, m_valid && m_regen && !s});
        chk({tag, "/halt"},   {31'd0, mem_halt},  {31'd0, m_halted});
        chk({tag, "/ldata"},  mem_loaddata, (m_pend && dhit) ? dmemload : m_load);
        if (m_pend) begin
            chk({tag, "/addr"},  dmemaddr,  m_alu);
            chk({tag, "/store"}, dmemstore, m_store);
        end
        if (m_valid) begin
            chk({tag, "/wsel"},   {27'd0, mem_wsel},   {27'd0, m_wsel});
            chk({tag, "/regsrc"}, {30'd0, mem_regsrc}, {30'd0, m_regsrc});
            chk({tag, "/alu"},    mem_aluout, m_alu);
            chk({tag, "/npc"},    mem_npc,    m_npc);
        end
    endtask

    task automatic model_edge();
        bit cap;
        if (nRST) begin
            m_pend = 0; m_halted = 0; m_load = '0;
            m_valid = 0; m_regen = 0; m_ren = 0; m_wen = 0;
            m_alu = '0; m_store = '0; m_npc = '0; m_wsel = '0; m_regsrc = '0;
            return;
        end
        cap = en && !(m_pend && !dhit) && !m_halted;
        if (m_pend && dhit) begin
            if (m_ren && !m_wen) m_load = dmemload;
            m_pend = 0;
        end
        if (cap) begin
            if (flush) begin
                m_valid = 0; m_regen = 0; m_ren = 0; m_wen = 0;
            end else begin
                m_valid = ex_valid; m_regen = ex_regen; m_ren = ex_dmemREN;
                m_wen = ex_dmemWEN; m_alu = ex_aluout; m_store = ex_storedata;
                m_npc = ex_npc; m_wsel = ex_wsel; m_regsrc = ex_regsrc;
                if (ex_valid && ex_halt) m_halted = 1;
                else if (ex_valid && (ex_dmemREN || ex_dmemWEN)) m_pend = 1;
            end
        end
    endtask

    task automatic step(input bit do_check, input string tag);
        #1;
        if (do_check) check_all(tag);
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic offer(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] ws,
                         input logic rg, input logic [1:0] rs, input logic rd,
                         input logic wr, input logic hl);
        en = 1; flush = 0; ex_valid = 1;
        ex_aluout = alu; ex_storedata = sd; ex_npc = alu + 32'h100;
        ex_wsel = ws; ex_regen = rg; ex_regsrc = rs;
        ex_dmemREN = rd; ex_dmemWEN = wr; ex_halt = hl;
    endtask

    initial begin
        nRST = 0; en = 0; flush = 0; dhit = 0; dmemload = '0;
        offer(32'h0, 32'h0, 5'd0, 0, 2'd0, 0, 0, 0);
        en = 0;

        // reset with an instruction offered
        nRST = 1; en = 1; ex_valid = 1; ex_dmemREN = 1;
        step(0, "rst0");
        step(1, "rst1");
        chk("rst/ren",   {31'd0, dmemREN},   32'd0);
        chk("rst/stall", {31'd0, mem_stall}, 32'd0);
        chk("rst/valid", {31'd0, mem_valid}, 32'd0);
        chk("rst/ldata", mem_loaddata,       32'd0);
        nRST = 0;

        // load held off by three miss cycles
        offer(32'h0000_0040, 32'h0, 5'd5, 1, 2'd1, 1, 0, 0);
        step(1, "lw_cap");
        offer(32'h0000_0077, 32'h0, 5'd6, 1, 2'd0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw/ren",   {31'd0, dmemREN},   32'd1);
            chk("lw/addr",  dmemaddr,           32'h40);
            chk("lw/stall", {31'd0, mem_stall}, 32'd1);
            step(1, "lw_wait");
        end
        dhit = 1; dmemload = 32'hDEAD_BEEF; en = 0;
        #1;
        chk("lw/hit_ldata", mem_loaddata,       32'hDEAD_BEEF);
        chk("lw/hit_regen", {31'd0, mem_regen}, 32'd1);
        chk("lw/hit_stall", {31'd0, mem_stall}, 32'd0);
        step(1, "lw_hit");
        dhit = 0; dmemload = 32'h0;
        #1;
        chk("lw/after_ren", {31'd0, dmemREN}, 32'd0);
        chk("lw/kept",      mem_loaddata,     32'hDEAD_BEEF);

        // store completing in its first cycle
        offer(32'h0000_0080, 32'h0000_1234, 5'd0, 0, 2'd0, 0, 1, 0);
        step(1, "sw_cap");
        en = 0; dhit = 1; dmemload = 32'h5555_AAAA;
        #1;
        chk("sw/wen",   {31'd0, dmemWEN},   32'd1);
        chk("sw/store", dmemstore,          32'h1234);
        chk("sw/stall", {31'd0, mem_stall}, 32'd0);
        step(1, "sw_hit");
        dhit = 0;
        #1;
        chk("sw/wen_off", {31'd0, dmemWEN},   32'd0);
        chk("sw/stall2",  {31'd0, mem_stall}, 32'd0);
        chk("sw/ldata",   mem_loaddata,       32'hDEAD_BEEF);

        // flush while stalled is ignored; the completing edge takes the bubble
        offer(32'h0000_0044, 32'h0, 5'd7, 1, 2'd1, 1, 0, 0);
        step(1, "fl_cap");
        offer(32'h0000_0099, 32'h0, 5'd8, 1, 2'd0, 0, 0, 0);
        flush = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("fl/stall", {31'd0, mem_stall}, 32'd1);
            chk("fl/ren",   {31'd0, dmemREN},   32'd1);
            step(1, "fl_wait");
        end
        dhit = 1; dmemload = 32'hCAFE_F00D;
        step(1, "fl_hit");
        dhit = 0; en = 0; flush = 0;
        #1;
        chk("fl/valid", {31'd0, mem_valid}, 32'd0);
        chk("fl/regen", {31'd0, mem_regen}, 32'd0);
        chk("fl/ldata", mem_loaddata,       32'hCAFE_F00D);

        // halt beats a memory op and freezes the stage until reset
        offer(32'h0000_0050, 32'h0, 5'd9, 1, 2'd0, 1, 0, 1);
        step(1, "ht_cap");
        en = 0;
        #1;
        chk("ht/halt", {31'd0, mem_halt}, 32'd1);
        chk("ht/ren",  {31'd0, dmemREN},  32'd0);
        for (int i = 0; i < 4; i++) begin
            offer($urandom, $urandom, 5'($urandom), 1, 2'($urandom), 1'($urandom), 1'($urandom), 0);
            dhit = 1'($urandom);
            step(1, "ht_hold");
        end
        #1;
        chk("ht/still", {31'd0, mem_halt}, 32'd1);
        chk("ht/alu",   mem_aluout,        32'h50);
        nRST = 1; en = 0; dhit = 0;
        step(1, "ht_rst");
        nRST = 0;

        // reset abandons an outstanding access
        offer(32'h0000_0060, 32'h0, 5'd3, 1, 2'd1, 1, 0, 0);
        step(1, "mr_cap1");
        en = 0; dhit = 1; dmemload = 32'h1111_2222;
        step(1, "mr_hit1");
        offer(32'h0000_0064, 32'h0, 5'd4, 1, 2'd1, 1, 0, 0);
        dhit = 0;
        step(1, "mr_cap2");
        en = 0;
        step(1, "mr_wait");
        nRST = 1;
        step(1, "mr_rst");
        chk("mr/ren",   {31'd0, dmemREN},   32'd0);
        chk("mr/stall", {31'd0, mem_stall}, 32'd0);
        chk("mr/ldata", mem_loaddata,       32'd0);
        nRST = 0;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            nRST         = ($urandom % 30) == 0;
            en           = ($urandom % 4) != 0;
            flush        = ($urandom % 6) == 0;
            ex_valid     = ($urandom % 8) != 0;
            ex_aluout    = $urandom;
            ex_storedata = $urandom;
            ex_npc       = $urandom;
            ex_wsel      = 5'($urandom);
            ex_regen     = 1'($urandom);
            ex_regsrc    = 2'($urandom);
            ex_dmemREN   = ($urandom % 3) == 0;
            ex_dmemWEN   = ($urandom % 3) == 0;
            ex_halt      = ($urandom % 40) == 0;
            dhit         = ($urandom % 3) == 0;
            dmemload     = $urandom;
            step(1, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
